// File: rtl/freq_sel_ctrl.sv
// freq_sel_ctrl: keypad-driven frequency index / amplitude sequencer that gates signal_m
// around every frequency change and requests bin2bcd conversions of the displayed index.
module freq_sel_ctrl #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [2:0]  boma,
    input  logic        bcd_done,
    output logic [3:0]  sel_idx,
    output logic        sel_wrap,
    output logic        sig_areset,
    output logic        sig_en,
    output logic [7:0]  amp_code,
    output logic        bcd_start,
    output logic [31:0] bcd_bin,
    output logic        busy,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;
    state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] idx_nx, last_idx;
    logic wrap_nx, last_wrap;
    logic idx_key, start_key, stop_key, changed, req, done, pending, outstanding;

    always_comb begin
        idx_key = 1'b0;
        start_key = 1'b0;
        stop_key = 1'b0;
        idx_nx = sel_idx;
        wrap_nx = sel_wrap;
        if (key_valid) begin
            idx_key = 1'b1;
            wrap_nx = 1'b0;
            case (key_code)
                4'b1100: begin idx_nx = sel_idx == 4'd9 ? 4'd0 : sel_idx + 4'd1; wrap_nx = sel_idx == 4'd9; end
                4'b1000: begin idx_nx = sel_idx == 4'd0 ? 4'd9 : sel_idx - 4'd1; wrap_nx = sel_idx == 4'd1; end
                4'b0111: idx_nx = 4'd1;
                4'b0110: idx_nx = 4'd2;
                4'b0101: idx_nx = 4'd3;
                4'b1011: idx_nx = 4'd4;
                4'b1010: idx_nx = 4'd5;
                4'b1001: idx_nx = 4'd6;
                4'b1111: idx_nx = 4'd7;
                4'b1110: idx_nx = 4'd8;
                4'b1101: idx_nx = 4'd9;
                4'b0011: begin idx_nx = 4'd0; wrap_nx = 1'b1; end
                4'b0010: begin idx_key = 1'b0; start_key = 1'b1; idx_nx = 4'd5; end
                default: begin idx_key = 1'b0; stop_key = key_code == 4'b0100; wrap_nx = sel_wrap; end
            endcase
        end
        changed = {wrap_nx, idx_nx} != {sel_wrap, sel_idx};
        state_nx = state;
        cnt_nx = cnt;
        if (stop_key)
            state_nx = IDLE;
        else if (start_key || (idx_key && (state == SETTLE || (state == RUN && changed)))) begin
            state_nx = SETTLE;
            cnt_nx = 8'd0;
        end else if (state == SETTLE) begin
            if (cnt == 8'(SETTLE_CYCLES - 1))
                state_nx = RUN;
            else
                cnt_nx = cnt + 8'd1;
        end
    end

    // A conversion is requested the cycle after the displayed value changes.
    assign req = {sel_wrap, sel_idx} != {last_wrap, last_idx};
    assign done = bcd_done && outstanding;
    assign busy = state == SETTLE || outstanding;
    assign state_o = state;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 8'd0;
            sel_idx <= 4'd0;
            sel_wrap <= 1'b0;
            last_idx <= 4'd0;
            last_wrap <= 1'b0;
            sig_areset <= 1'b1;
            sig_en <= 1'b0;
            amp_code <= 8'd0;
            bcd_start <= 1'b0;
            bcd_bin <= 32'd0;
            pending <= 1'b0;
            outstanding <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            sel_idx <= idx_nx;
            sel_wrap <= wrap_nx;
            last_idx <= sel_idx;
            last_wrap <= sel_wrap;
            sig_areset <= state_nx != RUN;
            sig_en <= state_nx == RUN;
            amp_code <= boma == 3'b100 ? 8'd1 : boma == 3'b010 ? 8'd2 : boma == 3'b001 ? 8'd5 : 8'd0;
            bcd_start <= 1'b0;
            if ((done && (pending || req)) || (!outstanding && req)) begin
                bcd_start <= 1'b1;
                bcd_bin <= {28'd0, sel_wrap ? 4'd10 : sel_idx};
                outstanding <= 1'b1;
                pending <= 1'b0;
            end else if (done)
                outstanding <= 1'b0;
            else if (req)
                pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_freq_sel_ctrl.sv
// tb_freq_sel_ctrl: directed + random stimulus against a display-value reference model,
// with a queue scoreboard for the bcd_start/bcd_bin conversion requests.
module tb_freq_sel_ctrl;
    localparam int N = 16;
    logic clk_50m = 1'b0;
    logic rst_n = 1'b0;
    logic key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [2:0] boma = 3'b000;
    logic bcd_done;
    logic [3:0] sel_idx;
    logic sel_wrap, sig_areset, sig_en, bcd_start, busy;
    logic [7:0] amp_code;
    logic [31:0] bcd_bin;
    logic [1:0] state_o;
    logic auto_done = 1'b1, done_auto = 1'b0, done_man = 1'b0, mon_en = 1'b0;
    int tests = 0, fails = 0, dly = 0;

    assign bcd_done = auto_done ? done_auto : done_man;

    freq_sel_ctrl #(.SETTLE_CYCLES(N)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .boma(boma), .bcd_done(bcd_done), .sel_idx(sel_idx), .sel_wrap(sel_wrap),
        .sig_areset(sig_areset), .sig_en(sig_en), .amp_code(amp_code), .bcd_start(bcd_start),
        .bcd_bin(bcd_bin), .busy(busy), .state_o(state_o)
    );

    always #10 clk_50m = ~clk_50m;

    // Model works on the displayed value 0..10 (10 means wrap set, index 0).
    int md, prev_d, ms, rem, e_bin, e_amp, nd, sbq[$];
    bit mout, mpend, exp_start, req, is_idx, st, sp;

    function automatic int digit(input logic [3:0] c);
        case (c)
            4'b0111: return 1; 4'b0110: return 2; 4'b0101: return 3;
            4'b1011: return 4; 4'b1010: return 5; 4'b1001: return 6;
            4'b1111: return 7; 4'b1110: return 8; 4'b1101: return 9;
            4'b0011: return 10;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk_50m) begin
        if (!rst_n) begin
            md = 0; prev_d = 0; ms = 0; rem = 0; mout = 0; mpend = 0;
            e_bin = 0; e_amp = 0; exp_start = 0; sbq.delete();
        end else begin
            req = md != prev_d;
            prev_d = md;
            exp_start = 0;
            if (bcd_done && mout) begin
                mout = 0;
                if (mpend || req) begin sbq.push_back(md); e_bin = md; exp_start = 1; mout = 1; mpend = 0; end
            end else if (req) begin
                if (mout) mpend = 1;
                else begin sbq.push_back(md); e_bin = md; exp_start = 1; mout = 1; end
            end
            is_idx = 0; nd = md;
            st = key_valid && key_code == 4'b0010;
            sp = key_valid && key_code == 4'b0100;
            if (key_valid && key_code == 4'b1100) begin is_idx = 1; nd = md == 9 ? 10 : md == 10 ? 1 : md + 1; end
            else if (key_valid && key_code == 4'b1000) begin is_idx = 1; nd = (md == 0 || md == 10) ? 9 : md == 1 ? 10 : md - 1; end
            else if (key_valid && digit(key_code) >= 0) begin is_idx = 1; nd = digit(key_code); end
            if (sp) ms = 0;
            else if (ms == 0) begin
                if (is_idx) md = nd;
                if (st) begin md = 5; ms = 1; rem = N; end
            end else if (ms == 1) begin
                if (is_idx || st) begin md = st ? 5 : nd; rem = N; end
                else if (rem == 1) ms = 2;
                else rem--;
            end else begin
                if (st) begin md = 5; ms = 1; rem = N; end
                else if (is_idx && nd != md) begin md = nd; ms = 1; rem = N; end
            end
            e_amp = boma == 3'b100 ? 1 : boma == 3'b010 ? 2 : boma == 3'b001 ? 5 : 0;
        end
    end

    logic [50:0] act, expv;
    always @(negedge clk_50m) begin
        if (mon_en) begin
            act = {sel_wrap, sel_idx, state_o, sig_areset, sig_en, amp_code, busy, bcd_start, bcd_bin};
            expv = {md == 10, 4'(md == 10 ? 0 : md), 2'(ms), ms != 2, ms == 2, 8'(e_amp),
                    ms == 1 || mout, exp_start, 32'(e_bin)};
            tests++;
            if (act !== expv) begin
                fails++;
                $display("FAIL outputs t=%0t act=%h exp=%h (wrap,idx,state,ares,en,amp,busy,start,bin)", $time, act, expv);
            end
            if (bcd_start) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL bcd_req t=%0t act=start bin=%0d exp=no request", $time, bcd_bin);
                end else if (bcd_bin !== 32'(sbq[0])) begin
                    fails++;
                    $display("FAIL bcd_bin t=%0t act=%0d exp=%0d", $time, bcd_bin, sbq[0]);
                end
                if (sbq.size() != 0) void'(sbq.pop_front());
            end
        end
    end

    always @(negedge clk_50m) begin
        done_auto = 1'b0;
        if (bcd_start) dly = $urandom_range(1, 6);
        else if (dly > 0) begin dly--; if (dly == 0) done_auto = 1'b1; end
        else if ($urandom_range(0, 63) == 0) done_auto = 1'b1;
    end

    task automatic press(input logic [3:0] c);
        @(negedge clk_50m);
        key_valid = 1'b1; key_code = c;
        @(negedge clk_50m);
        key_valid = 1'b0; key_code = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    initial begin
        idle(3);
        mon_en = 1'b1;
        rst_n = 1'b1;
        boma = 3'b100;
        press(4'b0010); idle(20);
        press(4'b1101); idle(20);
        press(4'b1101); idle(5);
        press(4'b1100); idle(20);
        press(4'b1000); idle(20);
        press(4'b1000); idle(20);
        auto_done = 1'b0; done_man = 1'b0;
        press(4'b0111); press(4'b0110); idle(3);
        done_man = 1'b1; idle(1); done_man = 1'b0; idle(3);
        done_man = 1'b1; idle(1); done_man = 1'b0; idle(2);
        auto_done = 1'b1;
        press(4'b0010); idle(7);
        press(4'b0100); idle(3);
        press(4'b0010); idle(20);
        rst_n = 1'b0; idle(1); rst_n = 1'b1; idle(2);
        boma = 3'b100; idle(2); boma = 3'b010; idle(2); boma = 3'b001; idle(2);
        boma = 3'b011; idle(2); boma = 3'b000; idle(2);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_50m);
            boma = 3'($urandom);
            rst_n = $urandom_range(0, 599) != 0;
            key_valid = $urandom_range(0, 23) == 0;
            key_code = 4'($urandom);
            if (key_code == 4'b0100 && $urandom_range(0, 1) == 0) key_code = 4'b0010;
        end
        key_valid = 1'b0; rst_n = 1'b1;
        idle(30);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL bcd_drain act=%0d queued exp=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
